// File: rtl/mux8_to_1.sv
// 8-to-1 WIDTH-bit selector with a combinational output and an enabled,
// registered copy (y_q) plus a one-cycle load strobe (valid_q).
module mux8_to_1 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  logic [WIDTH-1:0] i4,
   input  logic [WIDTH-1:0] i5,
   input  logic [WIDTH-1:0] i6,
   input  logic [WIDTH-1:0] i7,
   input  logic             s0,
   input  logic             s1,
   input  logic             s2,
   input  logic             en,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic             valid_q
);

   logic [2:0]       w_sel;
   logic [WIDTH-1:0] w_in [8];
   logic [WIDTH-1:0] r_y_q;
   logic             r_valid_q;

   assign w_sel = {s2, s1, s0};
   assign w_in  = '{i0, i1, i2, i3, i4, i5, i6, i7};

   // Every code selects a real input; an X/Z select yields all-X in simulation.
   assign y = w_in[w_sel];

   // NOTE: non-blocking assignments keep the sampled y the pre-edge value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_y_q     <= '0;
         r_valid_q <= 1'b0;
      end else if (en) begin
         r_y_q     <= y;
         r_valid_q <= 1'b1;
      end else begin
         r_valid_q <= 1'b0;
      end
   end

   assign y_q     = r_y_q;
   assign valid_q = r_valid_q;

endmodule

// File: tb/tb_mux8_to_1.sv
// Directed bench for mux8_to_1: combinational y checked inline, registered
// y_q/valid_q checked by a monitor against a queue of expected edge results.
module tb_mux8_to_1;

   typedef struct {
      logic [7:0] yq;
      logic       v;
      string      nm;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic [2:0] sel = 3'd0;
   logic [7:0] in8 [8];
   logic [7:0] in1 = 8'b1010_1010;  // i0..i7 = 0,1,0,1,0,1,0,1

   logic [7:0] d8_y, d8_yq;
   logic       d8_v;
   logic [0:0] d1_y, d1_yq;
   logic       d1_v;

   int   checks = 0;
   int   errors = 0;
   exp_t sb [$];

   always #5 clk = ~clk;

   mux8_to_1 #(.WIDTH(8)) u_d8 (
      .clk(clk), .rst(rst),
      .i0(in8[0]), .i1(in8[1]), .i2(in8[2]), .i3(in8[3]),
      .i4(in8[4]), .i5(in8[5]), .i6(in8[6]), .i7(in8[7]),
      .s0(sel[0]), .s1(sel[1]), .s2(sel[2]), .en(en),
      .y(d8_y), .y_q(d8_yq), .valid_q(d8_v)
   );

   mux8_to_1 #(.WIDTH(1)) u_d1 (
      .clk(clk), .rst(rst),
      .i0(in1[0]), .i1(in1[1]), .i2(in1[2]), .i3(in1[3]),
      .i4(in1[4]), .i5(in1[5]), .i6(in1[6]), .i7(in1[7]),
      .s0(sel[0]), .s1(sel[1]), .s2(sel[2]), .en(en),
      .y(d1_y), .y_q(d1_yq), .valid_q(d1_v)
   );

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock of stimulus: drive at the falling edge, check y at once,
   // and queue what the following rising edge must leave in y_q/valid_q.
   task automatic step(input logic [2:0] s, input logic e, input logic r,
                       input logic [7:0] ey, input logic [7:0] eyq,
                       input logic ev, input string nm);
      @(negedge clk);
      sel = s; en = e; rst = r;
      #1;
      check({nm, "_y"}, d8_y, ey);
      sb.push_back('{eyq, ev, nm});
   endtask

   // Monitor: after each rising edge, compare the registered outputs.
   always @(posedge clk) begin
      exp_t it;
      #2;
      if (sb.size() > 0) begin
         it = sb.pop_front();
         check({it.nm, "_valid_q"}, {7'd0, d8_v}, {7'd0, it.v});
         check({it.nm, "_y_q"}, d8_yq, it.yq);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int k = 0; k < 8; k++) in8[k] = 8'h01 << k;

      // Reset held two edges with en=1, sel=111: y live, registers cleared.
      step(3'd7, 1'b1, 1'b1, 8'h80, 8'h00, 1'b0, "rst_a");
      check("rst_a_w1_y", {7'd0, d1_y}, 8'h01);
      step(3'd7, 1'b1, 1'b1, 8'h80, 8'h00, 1'b0, "rst_b");
      check("rst_b_w1_y", {7'd0, d1_y}, 8'h01);
      step(3'd7, 1'b1, 1'b0, 8'h80, 8'h80, 1'b1, "rst_release");

      // One-hot sweep (WIDTH=8) with y_q following; WIDTH=1 y equals s0.
      step(3'd0, 1'b1, 1'b0, 8'h01, 8'h01, 1'b1, "oh0");
      check("w1_sel0", {7'd0, d1_y}, 8'h00);
      step(3'd1, 1'b1, 1'b0, 8'h02, 8'h02, 1'b1, "oh1");
      check("w1_sel1", {7'd0, d1_y}, 8'h01);
      step(3'd2, 1'b1, 1'b0, 8'h04, 8'h04, 1'b1, "oh2");
      check("w1_sel2", {7'd0, d1_y}, 8'h00);
      step(3'd3, 1'b1, 1'b0, 8'h08, 8'h08, 1'b1, "oh3");
      check("w1_sel3", {7'd0, d1_y}, 8'h01);
      step(3'd4, 1'b1, 1'b0, 8'h10, 8'h10, 1'b1, "oh4");
      check("w1_sel4", {7'd0, d1_y}, 8'h00);
      step(3'd5, 1'b1, 1'b0, 8'h20, 8'h20, 1'b1, "oh5");
      check("w1_sel5", {7'd0, d1_y}, 8'h01);
      step(3'd6, 1'b1, 1'b0, 8'h40, 8'h40, 1'b1, "oh6");
      check("w1_sel6", {7'd0, d1_y}, 8'h00);
      step(3'd7, 1'b1, 1'b0, 8'h80, 8'h80, 1'b1, "oh7");
      check("w1_sel7", {7'd0, d1_y}, 8'h01);

      // Enable hold: y moves immediately, y_q keeps the last load.
      step(3'd1, 1'b1, 1'b0, 8'h02, 8'h02, 1'b1, "hold_load");
      step(3'd0, 1'b0, 1'b0, 8'h01, 8'h02, 1'b0, "hold_a");
      step(3'd0, 1'b0, 1'b0, 8'h01, 8'h02, 1'b0, "hold_b");

      // Reset wins over en on the same edge; the next enabled edge loads.
      step(3'd1, 1'b1, 1'b1, 8'h02, 8'h00, 1'b0, "rst_prio");
      step(3'd1, 1'b1, 1'b0, 8'h02, 8'h02, 1'b1, "post_rst");

      // Data-only changes on i5 with sel fixed at 101.
      @(negedge clk);
      sel = 3'd5; en = 1'b1; rst = 1'b0; in8[5] = 8'h00;
      #1 check("d5_lo_y", d8_y, 8'h00);
      in8[5] = 8'h20;
      #1 check("d5_hi_y", d8_y, 8'h20);
      sb.push_back('{8'h20, 1'b1, "d5_cap_hi"});
      @(negedge clk);
      in8[5] = 8'h00;
      #1 check("d5_fall_y", d8_y, 8'h00);
      sb.push_back('{8'h00, 1'b1, "d5_cap_lo"});
      @(negedge clk);
      in8[5] = 8'h20;
      #1 check("d5_pulse_hi_y", d8_y, 8'h20);
      in8[5] = 8'h00;
      #1 check("d5_pulse_lo_y", d8_y, 8'h00);
      sb.push_back('{8'h00, 1'b1, "d5_cap_pulse"});

      // Select and data change together before an edge.
      @(negedge clk);
      sel = 3'd3; in8[3] = 8'hAA;
      #1 check("simul_y", d8_y, 8'hAA);
      sb.push_back('{8'hAA, 1'b1, "simul"});

      step(3'd0, 1'b0, 1'b0, 8'h01, 8'hAA, 1'b0, "idle_a");
      step(3'd6, 1'b0, 1'b0, 8'h40, 8'hAA, 1'b0, "idle_b");

      @(posedge clk);
      #3;
      check("scoreboard_drained", 8'(sb.size()), 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
